// File: rtl/retospect_pkg.sv
// Shared types and constants for the retospect configuration chain.
package retospect_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWaitByte,
    StShift,
    StFin
  } cfg_state_t;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  localparam int unsigned CLOCKBOX_BITS = 48;
  localparam int unsigned CNB_BITS      = 19;
  localparam int unsigned NUM_CNB       = 25;

  localparam int unsigned CHAIN_LEN_DEFAULT = CLOCKBOX_BITS + NUM_CNB * CNB_BITS;

endpackage

// File: rtl/retospect_crc8_serial.sv
// Bit-serial CRC-8 (MSB-first shift, no reflection, no final XOR, init 0).
module retospect_crc8_serial
  import retospect_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [7:0] crc
);

  logic [7:0] crc_q, crc_d;
  logic       fb;

  always_comb begin
    fb    = crc_q[7] ^ din;
    crc_d = {crc_q[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      crc_q <= '0;
    end else if (clr) begin
      crc_q <= '0;
    end else if (en) begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/retospect_cfg_loader.sv
// Byte-stream to serial shift-chain writer for the neurochip configuration chain.
// Define RETOSPECT_CFG_READBACK_EN to build the CRC readback check on the chain tail.
module retospect_cfg_loader
  import retospect_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = CHAIN_LEN_DEFAULT,
  parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       cfg_en,
  output logic       cfg_bs,
  input  logic       bs_ret,
  output logic       busy,
  output logic       done,
  output logic [7:0] crc_tx,
  output logic [7:0] crc_rx,
  output logic       crc_match
);

  localparam logic [CNT_W-1:0] LastBit = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] CntMax  = CNT_W'(CHAIN_LEN);

  cfg_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Bits 7..1 of the current byte; bit 0 lives in cfg_bs_q while it is on the chain.
  logic [6:0]       sr_q, sr_d;
  logic             cfg_en_q, cfg_en_d;
  logic             cfg_bs_q, cfg_bs_d;
  logic             load;
  logic             clr;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    cfg_bs_d   = 1'b0;
    byte_ready = 1'b0;
    done       = 1'b0;
    load       = 1'b0;
    clr        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StWaitByte;
          cnt_d   = '0;
          clr     = 1'b1;
        end
      end
      StWaitByte: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          load    = 1'b1;
          state_d = StShift;
        end
      end
      StShift: begin
        if (cnt_q != CntMax) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (cnt_q == LastBit) begin
          state_d = StFin;
        end else if (cnt_q[2:0] == 3'd7) begin
          // Last bit of this byte: take the next one now for gap-free streaming.
          byte_ready = 1'b1;
          if (byte_valid) begin
            load = 1'b1;
          end else begin
            state_d = StWaitByte;
          end
        end else begin
          sr_d     = {1'b0, sr_q[6:1]};
          cfg_bs_d = sr_q[0];
        end
      end
      StFin: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      sr_d     = byte_in[7:1];
      cfg_bs_d = byte_in[0];
    end

    cfg_en_d = (state_d == StShift);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      sr_q     <= '0;
      cfg_en_q <= 1'b0;
      cfg_bs_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sr_q     <= sr_d;
      cfg_en_q <= cfg_en_d;
      cfg_bs_q <= cfg_bs_d;
    end
  end

  assign cfg_en = cfg_en_q;
  assign cfg_bs = cfg_bs_q;
  assign busy   = (state_q != StIdle);

`ifdef RETOSPECT_CFG_READBACK_EN
  logic match_valid_q;

  retospect_crc8_serial u_crc_tx (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .en    (cfg_en_q),
    .din   (cfg_bs_q),
    .crc   (crc_tx)
  );

  // Tail bits leave the chain on the same edges the head bits enter it.
  retospect_crc8_serial u_crc_rx (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .en    (cfg_en_q),
    .din   (bs_ret),
    .crc   (crc_rx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      match_valid_q <= 1'b0;
    end else if (clr) begin
      match_valid_q <= 1'b0;
    end else if (state_d == StFin) begin
      match_valid_q <= 1'b1;
    end
  end

  assign crc_match = match_valid_q && (crc_tx == crc_rx);
`else
  logic unused_readback;
  assign unused_readback = bs_ret ^ clr;

  assign crc_tx    = 8'h00;
  assign crc_rx    = 8'h00;
  assign crc_match = 1'b0;
`endif

endmodule

// File: tb/tb_retospect_cfg_loader.sv
// Randomized bench for retospect_cfg_loader: a short chain (12 bits) and the default chain.
module tb_retospect_cfg_loader;

  localparam int LenA = 12;
  localparam int LenB = 523;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, sel, byte_valid;
  logic [7:0] byte_in;
  logic       start_a, start_b;

  logic       ready_a, en_a, bs_a, busy_a, done_a, match_a, ret_a;
  logic [7:0] tx_a, rx_a;
  logic       ready_b, en_b, bs_b, busy_b, done_b, match_b, ret_b;
  logic [7:0] tx_b, rx_b;

  assign start_a = start & ~sel;
  assign start_b = start & sel;

  retospect_cfg_loader #(.CHAIN_LEN(LenA)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(ready_a), .cfg_en(en_a), .cfg_bs(bs_a), .bs_ret(ret_a), .busy(busy_a),
    .done(done_a), .crc_tx(tx_a), .crc_rx(rx_a), .crc_match(match_a)
  );

  retospect_cfg_loader dut_b (
    .clk(clk), .reset(reset), .start(start_b), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(ready_b), .cfg_en(en_b), .cfg_bs(bs_b), .bs_ret(ret_b), .busy(busy_b),
    .done(done_b), .crc_tx(tx_b), .crc_rx(rx_b), .crc_match(match_b)
  );

  // Physical chains attached to each loader; not affected by loader reset.
  logic [LenA-1:0] chain_a = '0;
  logic [LenB-1:0] chain_b = '0;
  always @(posedge clk) if (en_a) chain_a <= {chain_a[LenA-2:0], bs_a};
  always @(posedge clk) if (en_b) chain_b <= {chain_b[LenB-2:0], bs_b};
  assign ret_a = chain_a[LenA-1];
  assign ret_b = chain_b[LenB-1];

  logic       o_ready, o_en, o_bs, o_busy, o_done, o_match;
  logic [7:0] o_tx, o_rx;
  assign o_ready = sel ? ready_b : ready_a;
  assign o_en    = sel ? en_b    : en_a;
  assign o_bs    = sel ? bs_b    : bs_a;
  assign o_busy  = sel ? busy_b  : busy_a;
  assign o_done  = sel ? done_b  : done_a;
  assign o_match = sel ? match_b : match_a;
  assign o_tx    = sel ? tx_b    : tx_a;
  assign o_rx    = sel ? rx_b    : rx_a;

  int checks = 0;
  int errors = 0;

  logic [7:0] img[$];
  // Reference chain contents, front = bit that next leaves the tail.
  bit chain_a_q[$];
  bit chain_b_q[$];

  task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] crc8(input bit b[$]);
    int unsigned c = 0;
    foreach (b[i]) begin
      c = c << 1;
      if ((((c >> 8) & 1) ^ b[i]) != 0) c = c ^ 32'h07;
      c = c & 32'hff;
    end
    return 8'(c);
  endfunction

  task automatic check_reset(input string name);
    chk({name, ".ready"}, o_ready, 0);
    chk({name, ".en"},    o_en,    0);
    chk({name, ".bs"},    o_bs,    0);
    chk({name, ".busy"},  o_busy,  0);
    chk({name, ".done"},  o_done,  0);
    chk({name, ".tx"},    o_tx,    0);
    chk({name, ".rx"},    o_rx,    0);
    chk({name, ".match"}, o_match, 0);
  endtask

  // Entered and left at a negedge. stall_idx/stall_len force one byte's stall.
  task automatic do_load(input string name, input int stall_max, input int stall_idx,
                         input int stall_len, input int poke_at, input int abort_at);
    int len, nbytes, cyc, idx, hs, nbits, stall_left, done_cnt, done_cyc, tot_stall, nshift;
    int stalls[$];
    logic [1023:0] obs_v, exp_v;
    logic [7:0] tx_o, rx_o, etx, erx, b;
    logic m_o, em, busy_after;
    bit sent[$], popped[$], cq[$];

    len = sel ? LenB : LenA;
    nbytes = (len + 7) / 8;
    tot_stall = 0;
    for (int i = 0; i < nbytes; i++) begin
      stalls.push_back((i == stall_idx) ? stall_len :
                       (stall_max > 0) ? int'($urandom_range(stall_max)) : 0);
      tot_stall += stalls[i];
    end
    exp_v = '0;
    obs_v = '0;
    for (int i = 0; i < len; i++) begin
      b = img[i / 8];
      sent.push_back(b[i % 8]);
      exp_v[i] = b[i % 8];
    end
    cq = sel ? chain_b_q : chain_a_q;
    nshift = (abort_at > 0) ? abort_at : len;
    for (int i = 0; i < nshift; i++) begin
      popped.push_back(cq.pop_front());
      cq.push_back(sent[i]);
    end
    if (sel) chain_b_q = cq;
    else chain_a_q = cq;
`ifdef RETOSPECT_CFG_READBACK_EN
    etx = crc8(sent);
    erx = crc8(popped);
    em  = (etx == erx);
`else
    etx = 8'h00;
    erx = 8'h00;
    em  = 1'b0;
`endif

    idx = 0; hs = 0; nbits = 0; done_cnt = 0; done_cyc = -1;
    tx_o = 'x; rx_o = 'x; m_o = 'x; busy_after = 'x;
    stall_left = stalls[0];
    byte_valid = 1'b0;
    start = 1'b1;
    @(posedge clk);
    cyc = 1;
    for (int g = 0; g < len + tot_stall + 20; g++) begin
      @(negedge clk);
      start = 1'b0;
      if (done_cnt > 0 && cyc == done_cyc + 1) begin
        busy_after = o_busy;
        if (o_done) done_cnt++;
        break;
      end
      if (o_en) begin
        if (nbits < 1024) obs_v[nbits] = o_bs;
        nbits++;
      end
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
        tx_o = o_tx;
        rx_o = o_rx;
        m_o = o_match;
      end
      if (abort_at > 0 && nbits == abort_at) break;
      if (poke_at > 0 && nbits == poke_at) start = 1'b1;
      if (o_ready && idx < nbytes && stall_left == 0) begin
        byte_valid = 1'b1;
        byte_in = img[idx];
      end else begin
        if (o_ready && stall_left > 0) stall_left--;
        // Garbage valid only where the loader is not ready; it must be ignored.
        byte_valid = !o_ready && ($urandom_range(3) == 0);
        byte_in = 8'($urandom);
      end
      if (byte_valid && o_ready) begin
        hs++;
        idx++;
        if (idx < nbytes) stall_left = stalls[idx];
      end
      @(posedge clk);
      cyc++;
    end
    byte_valid = 1'b0;
    start = 1'b0;

    if (abort_at > 0) begin
      chk({name, ".abort_bits"}, nbits, abort_at);
      return;
    end
    chk({name, ".nbits"},      nbits,      len);
    chk({name, ".bits"},       obs_v,      exp_v);
    chk({name, ".done_cnt"},   done_cnt,   1);
    chk({name, ".done_cyc"},   done_cyc,   len + 2 + tot_stall);
    chk({name, ".handshakes"}, hs,         nbytes);
    chk({name, ".crc_tx"},     tx_o,       etx);
    chk({name, ".crc_rx"},     rx_o,       erx);
    chk({name, ".crc_match"},  m_o,        em);
    chk({name, ".busy_after"}, busy_after, 0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    sel = 1'b0;
    byte_valid = 1'b0;
    byte_in = 8'h00;
    for (int i = 0; i < LenA; i++) chain_a_q.push_back(1'b0);
    for (int i = 0; i < LenB; i++) chain_b_q.push_back(1'b0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("rst_a");
    sel = 1'b1;
    #1 check_reset("rst_b");
    sel = 1'b0;
    reset = 1'b0;
    @(negedge clk);

    img = '{8'hA5, 8'h0F};
    do_load("basic", 0, -1, 0, 0, 0);
    do_load("stall", 0, 1, 5, 0, 0);
    do_load("poke", 0, -1, 0, 5, 0);

    do_load("abort", 0, -1, 0, 0, 6);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset("abort_rst");
    reset = 1'b0;
    @(negedge clk);
    img = '{8'($urandom), 8'($urandom)};
    do_load("fresh", 0, -1, 0, 0, 0);

    for (int n = 0; n < 6; n++) begin
      img = '{8'($urandom), 8'($urandom)};
      do_load($sformatf("rnd%0d", n), 3, -1, 0,
              (n % 2 == 1) ? int'($urandom_range(10, 1)) : 0, 0);
    end
    img = '{8'hA5, 8'h0F};
    do_load("again", 0, -1, 0, 0, 0);

    sel = 1'b1;
    @(negedge clk);
    img.delete();
    for (int i = 0; i < 66; i++) img.push_back(8'($urandom));
    do_load("len523", 0, -1, 0, 0, 0);
    img.delete();
    for (int i = 0; i < 66; i++) img.push_back(8'($urandom));
    do_load("len523s", 2, -1, 0, 100, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
